// File: rtl/upsample2x_stream.sv
// Streaming 2x nearest-neighbour upsampler: every input pixel becomes a 2x2 output block.
// Each row is sent once from the input and then replayed once from an internal line buffer.
//
// state | meaning
// ROW_A | first output copy of the row; pixels come from the input and are stored in linebuf
// ROW_B | second output copy of the row; pixels are replayed from linebuf and no input is taken
module upsample2x_stream #(
    parameter int IN_W = 14,
    parameter int IN_H = 14,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } phase_t;

    phase_t        phase_q, phase_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          dup_q, dup_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;

    logic [DW-1:0] linebuf [IN_W];

    logic          in_hs;
    logic          out_hs;
    logic          col_last;
    logic [CW-1:0] col_inc;
    logic          wr_en;
    logic [CW-1:0] wr_col;

    assign col_last = (col_q == COL_LAST);
    assign col_inc  = col_q + 1'b1;

    // The last column of ROW_A hands over to the replay, so the next input must wait
    // until the final copy of ROW_B; taking it earlier would clobber linebuf mid-replay.
    assign s_ready = !rst && (!m_valid_q ||
                     (m_ready && dup_q &&
                      ((phase_q == ROW_A && !col_last) || (phase_q == ROW_B && col_last))));

    assign in_hs  = s_valid && s_ready;
    assign out_hs = m_valid_q && m_ready;

    always_comb begin
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        dup_d     = dup_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        wr_en     = 1'b0;
        wr_col    = col_q;

        if (out_hs) begin
            if (!dup_q) begin
                dup_d = 1'b1;
            end else if (phase_q == ROW_A) begin
                dup_d = 1'b0;
                if (!col_last) begin
                    col_d     = col_inc;
                    m_valid_d = 1'b0;
                end else begin
                    phase_d  = ROW_B;
                    col_d    = '0;
                    m_data_d = linebuf[0];
                end
            end else begin
                dup_d = 1'b0;
                if (!col_last) begin
                    col_d    = col_inc;
                    m_data_d = linebuf[col_inc];
                end else begin
                    phase_d   = ROW_A;
                    col_d     = '0;
                    m_valid_d = 1'b0;
                    row_d     = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end
            end
        end

        // An accepted pixel always belongs to the column the state is moving to.
        if (in_hs) begin
            m_data_d  = s_data;
            m_valid_d = 1'b1;
            dup_d     = 1'b0;
            wr_en     = 1'b1;
            wr_col    = col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= ROW_A;
            col_q     <= '0;
            row_q     <= '0;
            dup_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            phase_q   <= phase_d;
            col_q     <= col_d;
            row_q     <= row_d;
            dup_q     <= dup_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            linebuf[wr_col] <= s_data;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_valid_q && (phase_q == ROW_B) && (row_q == ROW_LAST) &&
                     col_last && dup_q;

endmodule

// File: tb/tb_upsample2x_stream.sv
// Bench for upsample2x_stream: 14x14, 2x2 and 1x1 instances checked against an
// out[y][x] = in[y/2][x/2] reference with random valid/ready pacing.
module tb_upsample2x_stream;

    logic        clk = 1'b0;
    logic        rst;

    logic        s_valid, s_ready, m_valid, m_ready, m_last;
    logic [15:0] s_data, m_data;
    logic        s_valid2, s_ready2, m_valid2, m_ready2, m_last2;
    logic [15:0] s_data2, m_data2;
    logic        s_valid1, s_ready1, m_valid1, m_ready1, m_last1;
    logic [15:0] s_data1, m_data1;

    int errors = 0;
    int checks = 0;

    logic [15:0] fdata [196];
    logic [15:0] exp2 [16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};

    upsample2x_stream u_dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    upsample2x_stream #(.IN_W(2), .IN_H(2), .DW(16)) u_dut2 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2)
    );

    upsample2x_stream #(.IN_W(1), .IN_H(1), .DW(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives the 14x14 instance from fdata and checks every presented output against
    // the reference; span returns cycles between first and last output handshakes.
    task automatic run_main(input int pv, input int pr, input int n_out, output int span);
        int in_idx = 0;
        int oc = 0;
        int cyc = 0;
        int first = -1;
        int last_c = 0;
        int n_in;
        int k, y, x;
        bit hold = 1'b0;
        logic [15:0] hold_data = '0;
        logic exp_rdy;
        n_in = 196 * ((n_out + 783) / 784);
        while (oc < n_out && cyc < 20000) begin
            @(negedge clk);
            s_valid = (in_idx < n_in) && ($urandom_range(99) < pv);
            s_data  = fdata[in_idx % 196];
            m_ready = ($urandom_range(99) < pr);
            #1;
            if (hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
            end
            k = oc % 784;
            y = k / 28;
            x = k % 28;
            if (m_valid)
                exp_rdy = m_ready && (((y % 2 == 0) && (x % 2 == 1) && (x != 27)) ||
                                      ((y % 2 == 1) && (x == 27)));
            else
                exp_rdy = 1'b1;
            check("s_ready", s_ready, exp_rdy);
            if (m_valid && m_ready) begin
                check("data", m_data, fdata[(y / 2) * 14 + x / 2]);
                check("last", m_last, k == 783);
                if (first < 0) first = cyc;
                last_c = cyc;
                oc++;
            end
            if (s_valid && s_ready) in_idx++;
            hold      = m_valid && !m_ready;
            hold_data = m_data;
            cyc++;
        end
        check("out_count", oc, n_out);
        span = last_c - first;
    endtask

    initial begin
        int span;
        int ii, oo, cyc, first;

        for (int i = 0; i < 196; i++) fdata[i] = 16'(i);
        rst = 1'b1;
        s_valid = 0; s_data = '0; m_ready = 1'b1;
        s_valid2 = 0; s_data2 = '0; m_ready2 = 1'b1;
        s_valid1 = 0; s_data1 = '0; m_ready1 = 1'b1;

        repeat (3) @(negedge clk);
        s_valid = 1'b1;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_s_ready2", s_ready2, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", s_ready, 1);

        // 2x2 map, inputs 1..4, no backpressure
        ii = 0; oo = 0; cyc = 0; first = -1;
        while (oo < 16 && cyc < 100) begin
            @(negedge clk);
            s_valid2 = (ii < 4);
            s_data2  = 16'(ii + 1);
            #1;
            if (m_valid2) begin
                if (first < 0) first = cyc;
                check("d2_data", m_data2, exp2[oo]);
                check("d2_last", m_last2, oo == 15);
                check("d2_nobubble", cyc - first, oo);
                oo++;
            end
            if (s_valid2 && s_ready2) ii++;
            cyc++;
        end
        check("d2_count", oo, 16);
        s_valid2 = 1'b0;
        @(negedge clk);
        #1;
        check("d2_idle", m_valid2, 0);

        // 1x1 map, single pixel
        s_data1 = 16'hBEEF;
        ii = 0; oo = 0; cyc = 0;
        while (oo < 4 && cyc < 50) begin
            @(negedge clk);
            s_valid1 = (ii < 1);
            #1;
            if (m_valid1) begin
                check("d1_data", m_data1, 16'hBEEF);
                check("d1_last", m_last1, oo == 3);
                check("d1_s_ready", s_ready1, oo == 3);
                oo++;
            end
            if (s_valid1 && s_ready1) ii++;
            cyc++;
        end
        check("d1_count", oo, 4);
        s_valid1 = 1'b0;

        // Full rate, two back-to-back ramp frames
        run_main(100, 100, 1568, span);
        check("full_rate_span", span, 1567);

        // Random pacing, ramp frame
        run_main(60, 50, 784, span);

        // Random pacing, random pixel data
        for (int i = 0; i < 196; i++) fdata[i] = 16'($urandom);
        run_main(75, 50, 784, span);
        for (int i = 0; i < 196; i++) fdata[i] = 16'(i);

        // Reset in the middle of a frame, then a fresh frame
        run_main(100, 100, 100, span);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_s_ready", s_ready, 0);
        @(negedge clk);
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_last", m_last, 0);
        check("midrst_m_data", m_data, 0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", s_ready, 1);
        run_main(70, 70, 784, span);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
